// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - two-requester arbiter serialising fetches and loads/stores onto a byte-wide RAM/IO bus
module mem_ctrl #(
    parameter int         ADDR_W      = 32,
    parameter logic [1:0] IO_SEL      = 2'b11,
    parameter int         FETCH_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_valid,
    input  logic              lsb_is_store,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [2:0]        lsb_len,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic              last_lsb, last_lsb_n;
    logic              cur_lsb, cur_lsb_n;
    logic [ADDR_W-1:0] base, base_n, mem_a_n;
    logic [2:0]        len, len_n, idx, idx_n, nxt;
    logic [1:0]        slot;
    logic [31:0]       wdata, wdata_n, buf_q, buf_n, wsh;
    logic [31:0]       if_data_n, lsb_rdata_n;
    logic [7:0]        mem_dout_n;
    logic              mem_wr_n, if_done_n, lsb_done_n;
    logic              grant_lsb, grant_if;

    function automatic logic [2:0] len_decode(input logic [2:0] l);
        if (l == 3'd1)      return 3'd1;
        else if (l == 3'd2) return 3'd2;
        else                return 3'd4;
    endfunction

    always_comb begin
        state_n     = state;
        last_lsb_n  = last_lsb;
        cur_lsb_n   = cur_lsb;
        base_n      = base;
        len_n       = len;
        idx_n       = idx;
        wdata_n     = wdata;
        buf_n       = buf_q;
        mem_a_n     = mem_a;
        mem_dout_n  = mem_dout;
        mem_wr_n    = mem_wr;
        if_done_n   = if_done;
        if_data_n   = if_data;
        lsb_done_n  = lsb_done;
        lsb_rdata_n = lsb_rdata;
        nxt         = '0;
        slot        = '0;
        wsh         = '0;
        grant_lsb   = 1'b0;
        grant_if    = 1'b0;
        case (state)
            IDLE: begin
                if (!rollback) begin
                    // on a tie the requester that did not complete last wins
                    grant_lsb = lsb_valid && (!if_valid || !last_lsb);
                    grant_if  = if_valid && !grant_lsb;
                    if (grant_lsb || grant_if) begin
                        cur_lsb_n = grant_lsb;
                        base_n    = grant_lsb ? lsb_addr : if_addr;
                        len_n     = grant_lsb ? len_decode(lsb_len) : 3'(FETCH_BYTES);
                        wdata_n   = lsb_wdata;
                        idx_n     = '0;
                        mem_a_n   = grant_lsb ? lsb_addr : if_addr;
                        buf_n     = '0;
                        if (grant_lsb && lsb_is_store) begin
                            state_n    = WRITE;
                            mem_dout_n = lsb_wdata[7:0];
                            mem_wr_n   = !(lsb_addr[17:16] == IO_SEL && io_buffer_full);
                        end else begin
                            state_n = READ;
                        end
                    end
                end
            end
            READ: begin
                if (rollback) begin
                    state_n  = IDLE;
                    mem_wr_n = 1'b0;
                end else begin
                    // idx is the byte on mem_a; mem_din carries byte idx-1
                    if (idx != 3'd0) begin
                        slot = 2'(idx - 3'd1);
                        buf_n[{slot, 3'b000} +: 8] = mem_din;
                    end
                    if (idx == len) begin
                        state_n    = DONE;
                        last_lsb_n = cur_lsb;
                        if (cur_lsb) begin
                            lsb_done_n  = 1'b1;
                            lsb_rdata_n = buf_n;
                        end else begin
                            if_done_n = 1'b1;
                            if_data_n = buf_n;
                        end
                    end else begin
                        nxt   = idx + 3'd1;
                        idx_n = nxt;
                        if (nxt < len)
                            mem_a_n = base + ADDR_W'(nxt);
                    end
                end
            end
            WRITE: begin
                // a stalled byte (mem_wr low) is retried rather than skipped
                nxt = mem_wr ? idx + 3'd1 : idx;
                if (nxt == len) begin
                    state_n    = DONE;
                    mem_wr_n   = 1'b0;
                    lsb_done_n = 1'b1;
                    last_lsb_n = cur_lsb;
                end else begin
                    wsh        = wdata >> {nxt, 3'b000};
                    idx_n      = nxt;
                    mem_a_n    = base + ADDR_W'(nxt);
                    mem_dout_n = wsh[7:0];
                    mem_wr_n   = !(base[17:16] == IO_SEL && io_buffer_full);
                end
            end
            DONE: begin
                state_n    = IDLE;
                if_done_n  = 1'b0;
                lsb_done_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_lsb  <= 1'b0;
            cur_lsb   <= 1'b0;
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            wdata     <= '0;
            buf_q     <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            if_data   <= '0;
            lsb_done  <= 1'b0;
            lsb_rdata <= '0;
        end else if (rdy) begin
            state     <= state_n;
            last_lsb  <= last_lsb_n;
            cur_lsb   <= cur_lsb_n;
            base      <= base_n;
            len       <= len_n;
            idx       <= idx_n;
            wdata     <= wdata_n;
            buf_q     <= buf_n;
            mem_a     <= mem_a_n;
            mem_dout  <= mem_dout_n;
            mem_wr    <= mem_wr_n;
            if_done   <= if_done_n;
            if_data   <= if_data_n;
            lsb_done  <= lsb_done_n;
            lsb_rdata <= lsb_rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed bench for mem_ctrl with a byte RAM model and a done scoreboard
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_valid, lsb_is_store;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_len;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    typedef struct {
        logic        is_lsb;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    logic [7:0] ram [0:262143];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_valid(lsb_valid), .lsb_is_store(lsb_is_store), .lsb_addr(lsb_addr),
        .lsb_len(lsb_len), .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // one-cycle read latency RAM, also absorbing IO writes
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr)
            ram[mem_a[17:0]] <= mem_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input string tag, input int n, input int budget);
        int c = 0;
        for (int i = 0; i < budget && c < n; i++) begin
            tick();
            if (if_done || lsb_done) c++;
        end
        chk(tag, 32'(c), 32'(n));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (if_done || lsb_done)) begin
            chk("done_exclusive", 32'(if_done & lsb_done), 32'd0);
            tests++;
            assert (sbq.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_done: observed done with empty queue, expected no done");
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("done_source", 32'(lsb_done), 32'(e.is_lsb));
                if (e.chk_data)
                    chk("done_data", lsb_done ? lsb_rdata : if_data, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ram[18'h00100] <= 8'h13;
        ram[18'h00101] <= 8'h05;
        ram[18'h00102] <= 8'h00;
        ram[18'h00103] <= 8'h00;
        ram[18'h00080] <= 8'h9A;
        ram[18'h00202] <= 8'h77;
        ram[18'h3FFFE] <= 8'h11;
        ram[18'h3FFFF] <= 8'h22;
        ram[18'h00000] <= 8'h33;
        ram[18'h00001] <= 8'h44;

        // reset with random inputs, rdy included
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rdy            = 1'($urandom);
            rollback       = 1'($urandom);
            if_valid       = 1'($urandom);
            if_addr        = $urandom;
            lsb_valid      = 1'($urandom);
            lsb_is_store   = 1'($urandom);
            lsb_addr       = $urandom;
            lsb_len        = 3'($urandom);
            lsb_wdata      = $urandom;
            io_buffer_full = 1'($urandom);
            tick();
        end
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_lsb_done", 32'(lsb_done), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_rdata", lsb_rdata, 32'd0);
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; if_valid = 1'b0; lsb_valid = 1'b0;
        lsb_is_store = 1'b0; io_buffer_full = 1'b0; if_addr = '0; lsb_addr = '0;
        lsb_len = 3'd1; lsb_wdata = '0;
        tick();

        // continuous tie: LSB first after reset, then IF, then LSB
        if_addr = 32'h100; if_valid = 1'b1;
        lsb_addr = 32'h80; lsb_len = 3'd1; lsb_is_store = 1'b0; lsb_valid = 1'b1;
        sbq.push_back('{1'b1, 1'b1, 32'h0000009A});
        sbq.push_back('{1'b0, 1'b1, 32'h00000513});
        sbq.push_back('{1'b1, 1'b1, 32'h0000009A});
        wait_dones("tie_alternate", 3, 200);
        if_valid = 1'b0; lsb_valid = 1'b0;
        tick(); tick();

        // fetch with cycle-exact address stepping
        if_addr = 32'h100; if_valid = 1'b1;
        sbq.push_back('{1'b0, 1'b1, 32'h00000513});
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fetch_mem_a", mem_a, 32'h100 + i);
            chk("fetch_early_done", 32'(if_done), 32'd0);
        end
        tick();
        chk("fetch_done_t5", 32'(if_done), 32'd0);
        tick();
        chk("fetch_done_t6", 32'(if_done), 32'd1);
        chk("fetch_data", if_data, 32'h00000513);
        if_valid = 1'b0;
        tick();
        chk("fetch_done_clear", 32'(if_done), 32'd0);
        tick();

        // store len 2
        lsb_addr = 32'h200; lsb_len = 3'd2; lsb_wdata = 32'h1234ABCD;
        lsb_is_store = 1'b1; lsb_valid = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        tick();
        chk("st2_a0", mem_a, 32'h200);
        chk("st2_d0", 32'(mem_dout), 32'hCD);
        chk("st2_wr0", 32'(mem_wr), 32'd1);
        tick();
        chk("st2_a1", mem_a, 32'h201);
        chk("st2_d1", 32'(mem_dout), 32'hAB);
        chk("st2_wr1", 32'(mem_wr), 32'd1);
        tick();
        chk("st2_done", 32'(lsb_done), 32'd1);
        chk("st2_wr_done", 32'(mem_wr), 32'd0);
        lsb_valid = 1'b0;
        tick();
        chk("st2_ram200", 32'(ram[18'h200]), 32'hCD);
        chk("st2_ram201", 32'(ram[18'h201]), 32'hAB);
        chk("st2_ram202", 32'(ram[18'h202]), 32'h77);

        // IO store held off by a full write buffer
        lsb_addr = 32'h30000; lsb_len = 3'd1; lsb_wdata = 32'h0000005A;
        lsb_is_store = 1'b1; lsb_valid = 1'b1; io_buffer_full = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("io_stall_wr", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        tick();
        chk("io_wr", 32'(mem_wr), 32'd1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_dout", 32'(mem_dout), 32'h5A);
        chk("io_no_done", 32'(lsb_done), 32'd0);
        tick();
        chk("io_done", 32'(lsb_done), 32'd1);
        chk("io_wr_done", 32'(mem_wr), 32'd0);
        lsb_valid = 1'b0;
        tick();
        chk("io_ram", 32'(ram[18'h30000]), 32'h5A);

        // rollback aborts a fetch in its third cycle
        if_addr = 32'h100; if_valid = 1'b1;
        tick(); tick(); tick();
        rollback = 1'b1; if_valid = 1'b0;
        tick();
        rollback = 1'b0;
        chk("rb_fetch_wr", 32'(mem_wr), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rb_fetch_no_done", 32'(if_done), 32'd0);
            tick();
        end

        // aborted grant leaves last_grant at LSB, so IF wins this tie
        if_addr = 32'h100; if_valid = 1'b1;
        lsb_addr = 32'h100; lsb_len = 3'd2; lsb_is_store = 1'b0; lsb_valid = 1'b1;
        sbq.push_back('{1'b0, 1'b1, 32'h00000513});
        sbq.push_back('{1'b1, 1'b1, 32'h00000513});
        wait_dones("tie_after_abort_1", 1, 50);
        if_valid = 1'b0;
        wait_dones("tie_after_abort_2", 1, 50);
        lsb_valid = 1'b0;
        tick();

        // rollback during a committed 4-byte store
        lsb_addr = 32'h210; lsb_len = 3'd4; lsb_wdata = 32'hDEADBEEF;
        lsb_is_store = 1'b1; lsb_valid = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        tick(); tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("rb_st_a2", mem_a, 32'h212);
        chk("rb_st_wr2", 32'(mem_wr), 32'd1);
        tick();
        chk("rb_st_a3", mem_a, 32'h213);
        chk("rb_st_no_done", 32'(lsb_done), 32'd0);
        tick();
        chk("rb_st_done", 32'(lsb_done), 32'd1);
        lsb_valid = 1'b0;
        tick();
        chk("rb_st_ram", {ram[18'h213], ram[18'h212], ram[18'h211], ram[18'h210]}, 32'hDEADBEEF);

        // unusual length code reads four bytes
        lsb_addr = 32'h210; lsb_len = 3'd7; lsb_is_store = 1'b0; lsb_valid = 1'b1;
        sbq.push_back('{1'b1, 1'b1, 32'hDEADBEEF});
        wait_dones("len7_load", 1, 50);
        lsb_valid = 1'b0;
        tick();

        // fetch wrapping past the top of the address space
        if_addr = 32'hFFFFFFFE; if_valid = 1'b1;
        sbq.push_back('{1'b0, 1'b1, 32'h44332211});
        tick(); tick(); tick();
        chk("wrap_mem_a", mem_a, 32'h0);
        wait_dones("wrap_fetch", 1, 50);
        if_valid = 1'b0;
        tick();

        // rdy low freezes a store mid-flight
        lsb_addr = 32'h220; lsb_len = 3'd2; lsb_wdata = 32'h00006655;
        lsb_is_store = 1'b1; lsb_valid = 1'b1;
        sbq.push_back('{1'b1, 1'b0, 32'h0});
        tick();
        rdy = 1'b0;
        tick();
        chk("rdy_hold_a", mem_a, 32'h220);
        tick();
        chk("rdy_hold_a2", mem_a, 32'h220);
        chk("rdy_hold_wr", 32'(mem_wr), 32'd1);
        rdy = 1'b1;
        tick();
        chk("rdy_resume_a", mem_a, 32'h221);
        chk("rdy_resume_d", 32'(mem_dout), 32'h66);
        tick();
        chk("rdy_done", 32'(lsb_done), 32'd1);
        lsb_valid = 1'b0;
        tick(); tick();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller and arbiter between two requesters: instruction fetch (IF) and the load/store buffer (LSB).
- Drives the byte-wide synchronous RAM/IO bus.
- Serialises 1/2/4-byte loads and stores, and 4-byte fetches, into per-byte bus cycles.
- Returns assembled little-endian data to the granted requester with a one-cycle done pulse.

Parameters:
ADDR_W, 32, address width
IO_SEL, 2'b11, value of addr[17:16] that marks an IO-mapped address
FETCH_BYTES, 4, bytes per instruction fetch (fixed at 4 in this revision)

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global ready; low freezes all state
rollback  in  1  pipeline flush
if_valid  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle pulse, fetch complete
if_data  out  32  fetched word, valid with if_done
lsb_valid  in  1  LSB request, held until lsb_done
lsb_is_store  in  1  1 = store, 0 = load
lsb_addr  in  ADDR_W  access base address
lsb_len  in  3  access length in bytes: 1, 2 or 4
lsb_wdata  in  32  store data; byte i is bits 8i+7:8i
lsb_done  out  1  one-cycle pulse, access complete
lsb_rdata  out  32  raw load bytes, zero-extended; valid with lsb_done
mem_din  in  8  RAM read data
mem_dout  out  8  RAM write data
mem_a  out  ADDR_W  RAM address
mem_wr  out  1  RAM write strobe
io_buffer_full  in  1  IO write buffer cannot accept

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - All outputs are 0; state IDLE.
  - last_grant is set to IF, so the LSB wins the first tie.
  - rst overrides rdy.
- rdy low: every register holds its value, including outputs. Nothing advances.
- States: IDLE, READ, WRITE, DONE. All outputs are registered.
- IDLE arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant the requester other than last_grant; update last_grant.
  - Fetch is treated as a 4-byte read.
  - Grant at edge T latches addr, len, wdata and requester id.
  - Sets mem_a = addr and idx = 0.
  - A load goes to READ; a store goes to WRITE with mem_wr = 1 and mem_dout = byte 0.
- READ:
  - RAM read latency is 1 cycle: mem_din in cycle k holds the byte addressed by mem_a in cycle k-1.
  - Each cycle: present mem_a = base + next index and capture mem_din into byte slot idx-1.
  - After byte N-1 is captured, go to DONE with data registered.
  - The done pulse is high in cycle T+N+2 (fetch: T+6; LB: T+3).
- WRITE:
  - Cycle T+1+i drives mem_a = base+i, mem_dout = byte i, mem_wr = 1.
  - After byte N-1, go to DONE; the done pulse is high in cycle T+N+1 and mem_wr is 0 in that cycle.
- IO stall (store only):
  - Applies when addr[17:16] == IO_SEL and io_buffer_full is high at the edge that would issue a byte.
  - mem_wr is 0 the following cycle and idx does not advance.
  - The byte is issued at the first edge with io_buffer_full low.
- DONE:
  - The matching *_done is high for exactly one cycle; the other done is 0.
  - Then return to IDLE.
  - Requests are not sampled in the DONE cycle; a new grant is possible from the cycle after done.
- Data assembly:
  - Little-endian; byte i goes to/from base+i with no alignment requirement.
  - Unloaded upper bytes of lsb_rdata are 0; the LSB does sign extension.
  - lsb_len values other than 1 or 2 are treated as 4.
- Addresses: base+i wraps modulo 2^ADDR_W.
- rollback high at a clock edge (rdy high):
  - If serving a fetch or a load: abort, go to IDLE, mem_wr = 0, no done pulse.
  - A store in progress continues to completion, because stores are committed.
  - IDLE ignores if_valid in a rollback cycle and grants nothing.
  - A done pulse already on the outputs is not retracted.
  - last_grant is unchanged by an aborted grant.
- mem_wr is never 1 outside WRITE.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0; first tie after reset grants LSB.
- Fetch 0x100, RAM[0x100..0x103] = 13 05 00 00 -> mem_a steps 0x100..0x103 in cycles T+1..T+4; if_done high only in T+6; if_data = 0x00000513.
- Store len 2 to 0x200, wdata 0x1234ABCD -> T+1: a=0x200, dout=0xCD, wr=1; T+2: a=0x201, dout=0xAB, wr=1; lsb_done in T+3 with wr=0; RAM[0x202] untouched.
- if_valid and lsb_valid (load len 1 of 0x80) both high continuously -> grants alternate LSB, IF, LSB; lsb_rdata = 0x000000XX for byte 0xXX.
- Store len 1 to 0x30000 with io_buffer_full high for 3 cycles after grant -> mem_wr stays 0 for those cycles; byte written on the first cycle after release; lsb_done the next cycle.
- Rollback in cycle T+3 of a fetch -> no if_done, IDLE at T+4; rollback in T+2 of a 4-byte store -> all 4 bytes written, lsb_done at T+5.
